// File: rtl/pwm_cfg_controller.sv
// PWM configuration controller: owns the enable and duty registers and runs
// a timed fade engine that steps the duty cycle toward a programmed target.
// SPI register writes always take priority over the fade engine.
module pwm_cfg_controller #(
  parameter logic [7:0] STEP_SIZE      = 8'd1,
  parameter logic [7:0] INTERVAL_RESET = 8'd255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_strobe,
  input  logic [6:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       fade_busy,
  output logic       fade_done
);

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_DUTY      = 7'h04;
  localparam logic [6:0] ADDR_TARGET    = 7'h05;
  localparam logic [6:0] ADDR_INTERVAL  = 7'h06;

  typedef enum logic {StIdle, StRun} state_e;

  state_e     r_state;
  state_e     w_state_next;
  logic [7:0] r_en_out_lo, r_en_out_hi, r_en_pwm_lo, r_en_pwm_hi;
  logic [7:0] w_en_out_lo_next, w_en_out_hi_next, w_en_pwm_lo_next, w_en_pwm_hi_next;
  logic [7:0] r_duty, w_duty_next;
  logic [7:0] r_target, w_target_next;
  logic [7:0] r_interval, w_interval_next;
  logic [7:0] r_cnt, w_cnt_next;
  logic       r_done, w_done_next;

  // Step arithmetic signals
  logic       w_up;
  logic [8:0] w_dist;
  logic       w_arrive;
  logic [7:0] w_stepped;

  // Distance to target and the clamped next duty value for one fade step
  always_comb begin
    w_up = (r_target > r_duty);
    if (w_up) begin
      w_dist = {1'b0, r_target} - {1'b0, r_duty};
    end else begin
      w_dist = {1'b0, r_duty} - {1'b0, r_target};
    end
    w_arrive = (w_dist <= {1'b0, STEP_SIZE});
    // Landing exactly on target prevents overshoot and wrap past 0/255
    if (w_arrive) begin
      w_stepped = r_target;
    end else if (w_up) begin
      w_stepped = r_duty + STEP_SIZE;
    end else begin
      w_stepped = r_duty - STEP_SIZE;
    end
  end

  // Next-state logic: fade engine first, then register writes override it
  always_comb begin
    w_state_next     = r_state;
    w_en_out_lo_next = r_en_out_lo;
    w_en_out_hi_next = r_en_out_hi;
    w_en_pwm_lo_next = r_en_pwm_lo;
    w_en_pwm_hi_next = r_en_pwm_hi;
    w_duty_next      = r_duty;
    w_target_next    = r_target;
    w_interval_next  = r_interval;
    w_cnt_next       = r_cnt;
    w_done_next      = 1'b0;

    if (r_state == StRun) begin
      if (r_cnt != 8'd0) begin
        w_cnt_next = r_cnt - 8'd1;
      end else begin
        w_duty_next = w_stepped;
        w_cnt_next  = r_interval;
        if (w_arrive) begin
          w_state_next = StIdle;
          w_done_next  = 1'b1;
        end
      end
    end

    if (wr_strobe) begin
      case (wr_addr)
        ADDR_EN_OUT_LO: w_en_out_lo_next = wr_data;
        ADDR_EN_OUT_HI: w_en_out_hi_next = wr_data;
        ADDR_EN_PWM_LO: w_en_pwm_lo_next = wr_data;
        ADDR_EN_PWM_HI: w_en_pwm_hi_next = wr_data;
        ADDR_INTERVAL:  w_interval_next  = wr_data;
        ADDR_DUTY: begin
          // Direct write aborts any fade and discards a same-cycle step
          w_duty_next  = wr_data;
          w_state_next = StIdle;
          w_cnt_next   = 8'd0;
          w_done_next  = 1'b0;
        end
        ADDR_TARGET: begin
          // Retarget is judged against the pre-step duty; any step is dropped
          w_target_next = wr_data;
          w_duty_next   = r_duty;
          if (wr_data == r_duty) begin
            w_state_next = StIdle;
            w_cnt_next   = 8'd0;
            w_done_next  = 1'b1;
          end else begin
            w_state_next = StRun;
            w_cnt_next   = r_interval;
            w_done_next  = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // State and configuration registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_en_out_lo <= 8'h00;
      r_en_out_hi <= 8'h00;
      r_en_pwm_lo <= 8'h00;
      r_en_pwm_hi <= 8'h00;
      r_duty      <= 8'h00;
      r_target    <= 8'h00;
      r_interval  <= INTERVAL_RESET;
      r_cnt       <= 8'h00;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_en_out_lo <= w_en_out_lo_next;
      r_en_out_hi <= w_en_out_hi_next;
      r_en_pwm_lo <= w_en_pwm_lo_next;
      r_en_pwm_hi <= w_en_pwm_hi_next;
      r_duty      <= w_duty_next;
      r_target    <= w_target_next;
      r_interval  <= w_interval_next;
      r_cnt       <= w_cnt_next;
      r_done      <= w_done_next;
    end
  end

  assign en_reg_out_7_0  = r_en_out_lo;
  assign en_reg_out_15_8 = r_en_out_hi;
  assign en_reg_pwm_7_0  = r_en_pwm_lo;
  assign en_reg_pwm_15_8 = r_en_pwm_hi;
  assign pwm_duty_cycle  = r_duty;
  assign fade_busy       = (r_state == StRun);
  assign fade_done       = r_done;

endmodule

// File: tb/tb_pwm_cfg_controller.sv
// Directed bench for pwm_cfg_controller; expected values are queued with each
// stimulus step and popped/compared once the DUT has produced its output.
module tb_pwm_cfg_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_strobe;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] en0, en1, en2, en3, duty, duty4;
  logic [7:0] en0_4, en1_4, en2_4, en3_4;
  logic       busy, done, busy4, done4;

  always #5 clk = ~clk;

  pwm_cfg_controller #(.STEP_SIZE(8'd1), .INTERVAL_RESET(8'd255)) u_dut (
    .clk(clk), .rst_n(rst_n), .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
    .en_reg_out_7_0(en0), .en_reg_out_15_8(en1), .en_reg_pwm_7_0(en2), .en_reg_pwm_15_8(en3),
    .pwm_duty_cycle(duty), .fade_busy(busy), .fade_done(done)
  );

  pwm_cfg_controller #(.STEP_SIZE(8'd4), .INTERVAL_RESET(8'd255)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
    .en_reg_out_7_0(en0_4), .en_reg_out_15_8(en1_4), .en_reg_pwm_7_0(en2_4),
    .en_reg_pwm_15_8(en3_4), .pwm_duty_cycle(duty4), .fade_busy(busy4), .fade_done(done4)
  );

  localparam int SEn0 = 0, SEn1 = 1, SEn2 = 2, SEn3 = 3, SDuty = 4, SBusy = 5, SDone = 6;
  localparam int SDuty4 = 7, SBusy4 = 8, SDone4 = 9, SEn0_4 = 10, SEn3_4 = 11;

  typedef struct {
    string      tag;
    int         sel;
    logic [7:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [7:0] obs(input int sel);
    case (sel)
      SEn0:    obs = en0;
      SEn1:    obs = en1;
      SEn2:    obs = en2;
      SEn3:    obs = en3;
      SDuty:   obs = duty;
      SBusy:   obs = {7'd0, busy};
      SDone:   obs = {7'd0, done};
      SDuty4:  obs = duty4;
      SBusy4:  obs = {7'd0, busy4};
      SDone4:  obs = {7'd0, done4};
      SEn0_4:  obs = en0_4;
      SEn3_4:  obs = en3_4;
      default: obs = 8'hxx;
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [7:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic exp1(input string tag, input logic [7:0] d, input logic b, input logic f);
    push({tag, ".duty"}, SDuty, d);
    push({tag, ".busy"}, SBusy, {7'd0, b});
    push({tag, ".done"}, SDone, {7'd0, f});
  endtask

  task automatic exp4(input string tag, input logic [7:0] d, input logic b, input logic f);
    push({tag, ".duty4"}, SDuty4, d);
    push({tag, ".busy4"}, SBusy4, {7'd0, b});
    push({tag, ".done4"}, SDone4, {7'd0, f});
  endtask

  task automatic drain();
    exp_t       e;
    logic [7:0] o;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      o = obs(e.sel);
      checks++;
      assert (o === e.exp) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, o, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    wr_strobe = 1'b1;
    wr_addr   = a;
    wr_data   = d;
    @(negedge clk);
    wr_strobe = 1'b0;
    wr_addr   = 7'd0;
    wr_data   = 8'd0;
  endtask

  task automatic exp_all_zero(input string tag);
    push({tag, ".en0"}, SEn0, 8'h00);
    push({tag, ".en1"}, SEn1, 8'h00);
    push({tag, ".en2"}, SEn2, 8'h00);
    push({tag, ".en3"}, SEn3, 8'h00);
    exp1(tag, 8'h00, 1'b0, 1'b0);
    push({tag, ".en0_4"}, SEn0_4, 8'h00);
    push({tag, ".en3_4"}, SEn3_4, 8'h00);
    exp4(tag, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n     = 1'b0;
    wr_strobe = 1'b0;
    wr_addr   = 7'd0;
    wr_data   = 8'd0;
    repeat (2) tick();
    exp_all_zero("reset");
    drain();
    rst_n = 1'b1;
    tick();

    // Register writes and an unmapped address
    wr(7'h00, 8'hA5);
    push("wr00.en0", SEn0, 8'hA5);
    push("wr00.en3", SEn3, 8'h00);
    drain();
    wr(7'h03, 8'h3C);
    push("wr03.en0", SEn0, 8'hA5);
    push("wr03.en1", SEn1, 8'h00);
    push("wr03.en2", SEn2, 8'h00);
    push("wr03.en3", SEn3, 8'h3C);
    exp1("wr03", 8'h00, 1'b0, 1'b0);
    drain();
    wr(7'h7F, 8'hFF);
    push("wr7f.en0", SEn0, 8'hA5);
    push("wr7f.en1", SEn1, 8'h00);
    push("wr7f.en2", SEn2, 8'h00);
    push("wr7f.en3", SEn3, 8'h3C);
    exp1("wr7f", 8'h00, 1'b0, 1'b0);
    drain();

    // Interval 2 fade 0x10 -> 0x14: steps at 3, 6, 9, 12 clocks after accept
    wr(7'h06, 8'd2);
    wr(7'h04, 8'h10);
    exp1("int2.pre", 8'h10, 1'b0, 1'b0);
    drain();
    wr(7'h05, 8'h14);
    exp1("int2.acc", 8'h10, 1'b1, 1'b0);
    drain();
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp1($sformatf("int2.k%0d", k), 8'h10 + 8'(k / 3), (k < 12), (k == 12));
      drain();
    end
    tick();
    exp1("int2.after", 8'h14, 1'b0, 1'b0);
    drain();

    // STEP_SIZE 4 descent 0xFE -> 0x05 at interval 0: 63 steps, no wrap
    wr(7'h06, 8'd0);
    wr(7'h04, 8'hFE);
    wr(7'h05, 8'h05);
    exp4("s4.acc", 8'hFE, 1'b1, 1'b0);
    drain();
    for (int k = 1; k <= 64; k++) begin
      tick();
      exp4($sformatf("s4.k%0d", k), (k >= 63) ? 8'h05 : 8'(254 - 4 * k), (k < 63), (k == 63));
      push($sformatf("s1.k%0d.duty", k), SDuty, 8'(254 - k));
      drain();
    end

    // Direct duty write aborts a fade in the same cycle as a step
    wr(7'h04, 8'h00);
    wr(7'h05, 8'h80);
    for (int k = 1; k <= 32; k++) begin
      tick();
      exp1($sformatf("abort.k%0d", k), 8'(k), 1'b1, 1'b0);
      drain();
    end
    wr(7'h04, 8'h55);
    exp1("abort.wr", 8'h55, 1'b0, 1'b0);
    drain();
    for (int k = 1; k <= 3; k++) begin
      tick();
      exp1($sformatf("abort.hold%0d", k), 8'h55, 1'b0, 1'b0);
      drain();
    end

    // Mid-fade retarget 0x00 -> 0xFF, then 0x10 at duty 0x30
    wr(7'h04, 8'h00);
    wr(7'h05, 8'hFF);
    for (int k = 1; k <= 48; k++) begin
      tick();
      exp1($sformatf("rt.up%0d", k), 8'(k), 1'b1, 1'b0);
      drain();
    end
    wr(7'h05, 8'h10);
    exp1("rt.acc", 8'h30, 1'b1, 1'b0);
    drain();
    for (int k = 1; k <= 32; k++) begin
      tick();
      exp1($sformatf("rt.dn%0d", k), 8'(48 - k), (k < 32), (k == 32));
      drain();
    end
    tick();
    exp1("rt.after", 8'h10, 1'b0, 1'b0);
    drain();

    // Asynchronous reset mid-fade
    wr(7'h04, 8'h00);
    wr(7'h05, 8'hFF);
    repeat (5) tick();
    exp1("rst.pre", 8'h05, 1'b1, 1'b0);
    drain();
    #2 rst_n = 1'b0;
    #1;
    exp_all_zero("rst.async");
    drain();
    tick();
    rst_n = 1'b1;
    tick();
    wr(7'h05, 8'h00);
    exp1("rst.t0", 8'h00, 1'b0, 1'b1);
    exp4("rst.t0", 8'h00, 1'b0, 1'b1);
    drain();
    tick();
    exp1("rst.t0n", 8'h00, 1'b0, 1'b0);
    drain();

    // Reset interval is INTERVAL_RESET: first step lands 256 clocks after accept
    wr(7'h05, 8'h01);
    exp1("ivr.acc", 8'h00, 1'b1, 1'b0);
    drain();
    repeat (255) tick();
    exp1("ivr.k255", 8'h00, 1'b1, 1'b0);
    drain();
    tick();
    exp1("ivr.k256", 8'h01, 1'b0, 1'b1);
    exp4("ivr.k256", 8'h01, 1'b0, 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
